// File: rtl/edge_event_arbiter.sv
// Multi-channel event front end: synchronize, debounce and edge-detect each input,
// hold one pending event per channel and hand events out round-robin over valid/ready.
module edge_event_arbiter #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_LEVELS     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                          clk_i,
    input  logic                          srst_i,
    input  logic [CHANNELS-1:0]           data_i,
    input  logic [CHANNELS-1:0]           rise_en_i,
    input  logic [CHANNELS-1:0]           fall_en_i,
    output logic [CHANNELS-1:0]           level_o,
    output logic                          evt_valid_o,
    input  logic                          evt_ready_i,
    output logic [$clog2(CHANNELS)-1:0]   evt_channel_o,
    output logic                          evt_rising_o,
    output logic [CHANNELS-1:0]           ovf_o,
    input  logic [CHANNELS-1:0]           ovf_clr_i
);

    localparam int CW = $clog2(CHANNELS);
    localparam int IW = CW + 1;
    localparam int NW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [NW-1:0] CNT_MAX  = NW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IW-1:0] CH_COUNT = IW'(CHANNELS);
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

    logic [CHANNELS-1:0] sync_ff [SYNC_LEVELS];
    logic [CHANNELS-1:0] sync;
    logic [CHANNELS-1:0] deb;
    logic [CHANNELS-1:0] deb_q;
    logic [NW-1:0]       cnt [CHANNELS];
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] edge_hit;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] pol;
    logic [CHANNELS-1:0] ovf;
    logic [CHANNELS-1:0] loaded;
    logic [CW-1:0]       ptr;
    logic [CW-1:0]       winner;
    logic [IW-1:0]       idx;
    logic                found;
    logic                load;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < SYNC_LEVELS; i++) sync_ff[i] <= '0;
        end else begin
            sync_ff[0] <= data_i;
            for (int i = 1; i < SYNC_LEVELS; i++) sync_ff[i] <= sync_ff[i-1];
        end
    end

    assign sync = sync_ff[SYNC_LEVELS-1];

    // A changed level is accepted only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            deb   <= '0;
            deb_q <= '0;
            for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
        end else begin
            deb_q <= deb;
            for (int c = 0; c < CHANNELS; c++) begin
                if (sync[c] == deb[c]) begin
                    cnt[c] <= '0;
                end else if (cnt[c] == CNT_MAX) begin
                    deb[c] <= sync[c];
                    cnt[c] <= '0;
                end else begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    assign rise     = deb & ~deb_q & rise_en_i;
    assign fall     = ~deb & deb_q & fall_en_i;
    assign edge_hit = rise | fall;

    // First pending channel at or after ptr, wrapping modulo CHANNELS.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = {1'b0, ptr} + IW'(i);
            if (idx >= CH_COUNT) idx = idx - CH_COUNT;
            if (!found && pend[idx[CW-1:0]]) begin
                found  = 1'b1;
                winner = idx[CW-1:0];
            end
        end
    end

    assign load   = (!evt_valid_o || evt_ready_i) && found;
    assign loaded = load ? (CHANNELS'(1) << winner) : '0;

    // A slot load frees the winner's pend bit in the same cycle, so a new edge there is kept.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            pend <= '0;
            pol  <= '0;
            ovf  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (edge_hit[c] && (!pend[c] || loaded[c])) begin
                    pend[c] <= 1'b1;
                    pol[c]  <= rise[c];
                end else if (loaded[c]) begin
                    pend[c] <= 1'b0;
                end
            end
            ovf <= (ovf & ~ovf_clr_i) | (edge_hit & pend & ~loaded);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            evt_valid_o   <= 1'b0;
            evt_channel_o <= '0;
            evt_rising_o  <= 1'b0;
            ptr           <= '0;
        end else if (load) begin
            evt_valid_o   <= 1'b1;
            evt_channel_o <= winner;
            evt_rising_o  <= pol[winner];
            ptr           <= (winner == CH_LAST) ? '0 : winner + 1'b1;
        end else if (evt_ready_i) begin
            evt_valid_o   <= 1'b0;
        end
    end

    assign level_o = deb;
    assign ovf_o   = ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: expected events are queued as stimulus
// is applied and compared as the DUT hands them out.
module tb_edge_event_arbiter;

    typedef struct packed {
        logic [1:0] ch;
        logic       rising;
    } evt_t;

    logic       clk = 1'b0;
    logic       srst;
    logic [3:0] data;
    logic [3:0] rise_en;
    logic [3:0] fall_en;
    logic [3:0] level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_channel;
    logic       evt_rising;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int   n_cmp = 0;
    int   n_bad = 0;
    evt_t exp_q[$];
    evt_t got;

    edge_event_arbiter #(
        .CHANNELS(4), .SYNC_LEVELS(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .data_i       (data),
        .rise_en_i    (rise_en),
        .fall_en_i    (fall_en),
        .level_o      (level),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (evt_ready),
        .evt_channel_o(evt_channel),
        .evt_rising_o (evt_rising),
        .ovf_o        (ovf),
        .ovf_clr_i    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst    = 1'b1;
        data    = '0;
        ovf_clr = '0;
        tick(2);
        exp_q.delete();
        srst    = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
        chk({tag, "_ch"}, 32'(evt_channel), 32'd0);
        chk({tag, "_rising"}, 32'(evt_rising), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    // Accepted handshakes are popped against the scoreboard; inputs only change at posedge+1.
    always @(negedge clk) begin
        if (!srst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("evt_extra", 32'(evt_valid), 32'd0);
            end else begin
                got = exp_q.pop_front();
                chk("evt_ch", 32'(evt_channel), 32'(got.ch));
                chk("evt_rise", 32'(evt_rising), 32'(got.rising));
            end
        end
    end

    initial begin
        srst      = 1'b1;
        data      = '0;
        rise_en   = 4'hF;
        fall_en   = 4'hF;
        evt_ready = 1'b0;
        ovf_clr   = '0;
        tick(3);
        chk_all_zero("reset");
        srst = 1'b0;
        tick(1);

        // Single rising edge on channel 2: level after edge 6, event after edge 8.
        evt_ready = 1'b1;
        exp_q.push_back('{ch: 2'd2, rising: 1'b1});
        data[2] = 1'b1;
        tick(5);
        chk("lat_level_e5", 32'(level[2]), 32'd0);
        tick(1);
        chk("lat_level_e6", 32'(level[2]), 32'd1);
        tick(1);
        chk("lat_valid_e7", 32'(evt_valid), 32'd0);
        tick(1);
        chk("lat_valid_e8", 32'(evt_valid), 32'd1);
        chk("lat_ch", 32'(evt_channel), 32'd2);
        chk("lat_rising", 32'(evt_rising), 32'd1);
        tick(1);
        chk("lat_valid_e9", 32'(evt_valid), 32'd0);
        chk("lat_q", 32'(exp_q.size()), 32'd0);

        // Three-cycle glitch on channel 0 is filtered.
        do_reset();
        evt_ready = 1'b1;
        data[0] = 1'b1;
        tick(3);
        data[0] = 1'b0;
        tick(12);
        chk("glitch_level", 32'(level[0]), 32'd0);
        chk("glitch_valid", 32'(evt_valid), 32'd0);
        chk("glitch_ovf", 32'(ovf), 32'd0);

        // Simultaneous burst: one event per cycle in channel order, twice.
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back('{ch: 2'(i), rising: 1'b1});
        data = 4'hF;
        tick(7);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("burst1_valid", 32'(evt_valid), 32'd1);
            chk("burst1_ch", 32'(evt_channel), 32'(i));
        end
        drain(5);
        tick(3);
        for (int i = 0; i < 4; i++) exp_q.push_back('{ch: 2'(i), rising: 1'b0});
        data = 4'h0;
        tick(7);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("burst2_valid", 32'(evt_valid), 32'd1);
            chk("burst2_ch", 32'(evt_channel), 32'(i));
        end
        drain(5);
        tick(1);
        chk("burst_idle", 32'(evt_valid), 32'd0);

        // Backpressure: slot + pend on channel 1, then overflow and set-beats-clear.
        do_reset();
        evt_ready = 1'b0;
        exp_q.push_back('{ch: 2'd1, rising: 1'b1});
        data[1] = 1'b1;
        tick(10);
        chk("bp_valid", 32'(evt_valid), 32'd1);
        chk("bp_ch", 32'(evt_channel), 32'd1);
        chk("bp_rising", 32'(evt_rising), 32'd1);
        exp_q.push_back('{ch: 2'd1, rising: 1'b0});
        data[1] = 1'b0;
        tick(10);
        chk("bp_hold_rising", 32'(evt_rising), 32'd1);
        chk("bp_no_ovf", 32'(ovf), 32'd0);
        data[1] = 1'b1;
        tick(10);
        chk("bp_ovf_set", 32'(ovf), 32'h2);
        chk("bp_hold_ch", 32'(evt_channel), 32'd1);
        ovf_clr = 4'h2;
        tick(1);
        ovf_clr = 4'h0;
        chk("bp_ovf_clr", 32'(ovf), 32'd0);
        data[1] = 1'b0;
        tick(6);
        ovf_clr = 4'h2;
        tick(1);
        ovf_clr = 4'h0;
        chk("bp_set_wins", 32'(ovf), 32'h2);
        evt_ready = 1'b1;
        drain(10);
        tick(5);
        chk("bp_no_third", 32'(evt_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(ovf), 32'h2);

        // Rising disabled on channel 3: only the falling edge is reported.
        do_reset();
        evt_ready = 1'b1;
        rise_en   = 4'b0111;
        data[3] = 1'b1;
        tick(12);
        chk("en_level_hi", 32'(level[3]), 32'd1);
        chk("en_no_rise", 32'(evt_valid), 32'd0);
        exp_q.push_back('{ch: 2'd3, rising: 1'b0});
        data[3] = 1'b0;
        tick(6);
        chk("en_level_lo", 32'(level[3]), 32'd0);
        drain(10);
        rise_en = 4'hF;

        // Reset mid-operation discards the slot and pending events.
        do_reset();
        evt_ready = 1'b0;
        data = 4'b0111;
        tick(10);
        chk("mid_valid", 32'(evt_valid), 32'd1);
        chk("mid_ch", 32'(evt_channel), 32'd0);
        srst = 1'b1;
        data = 4'b0000;
        tick(1);
        chk_all_zero("mid_rst");
        tick(1);
        srst = 1'b0;
        evt_ready = 1'b1;
        tick(20);
        chk("mid_after", 32'(evt_valid), 32'd0);
        chk("mid_ovf", 32'(ovf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel input event controller.
- Each channel:
  - synchronizes an asynchronous level input,
  - debounces it,
  - detects enabled rising/falling edges,
  - queues one pending event.
- A round-robin arbiter shares one registered event output (valid/ready) among all channels.
- Sits between raw board/peripheral inputs and the interrupt/event logic. It replaces ad-hoc per-input edge detection.

Parameters:
- CHANNELS, 4: number of input channels (>=2).
- SYNC_LEVELS, 2: synchronizer flops per channel (>=2).
- DEBOUNCE_CYCLES, 4: consecutive cycles a changed synchronized level must hold before it is accepted (>=1).

Ports:
- clk_i  input  1  clock.
- srst_i  input  1  synchronous reset, active-high.
- data_i  input  CHANNELS  raw asynchronous channel levels.
- rise_en_i  input  CHANNELS  per-channel rising-edge event enable.
- fall_en_i  input  CHANNELS  per-channel falling-edge event enable.
- level_o  output  CHANNELS  debounced levels.
- evt_valid_o  output  1  event slot holds an event.
- evt_ready_i  input  1  consumer accepts the event.
- evt_channel_o  output  $clog2(CHANNELS)  channel index of the event.
- evt_rising_o  output  1  1 = rising edge, 0 = falling edge.
- ovf_o  output  CHANNELS  sticky per-channel overflow flags.
- ovf_clr_i  input  CHANNELS  one-cycle clear mask for ovf_o.

Behaviour:
- One clock domain (clk_i). Reset is synchronous, active-high. All state is updated only on the rising edge of clk_i.
- Reset (srst_i=1 at a clock edge) clears all state:
  - synchronizer flops, debounced levels and debounce counters;
  - pending bits, output slot and overflow flags;
  - RR pointer set to 0.
- Outputs in reset: level_o=0, evt_valid_o=0, evt_channel_o=0, evt_rising_o=0, ovf_o=0.
- Reset mid-operation discards pending and in-flight events with no handshake.
- A channel held high through reset reports a rising edge after the normal latency.
- Synchronizer: SYNC_LEVELS-deep flop chain per channel. sync = last stage.
- Debounce, per channel, with counter cnt of width $clog2(DEBOUNCE_CYCLES)+1:
  - sync==deb: cnt<=0.
  - sync!=deb and cnt==DEBOUNCE_CYCLES-1: deb<=sync, cnt<=0.
  - otherwise: cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes deb.
  - level_o = deb.
- Edge detect: rise = deb changes 0->1 at a clock edge; fall = deb changes 1->0. An edge is "enabled" if rise_en_i (rise) or fall_en_i (fall) is high in the cycle the edge is detected. Disabled edges are dropped silently.
- Pending, per channel: pend bit plus pol bit.
  - Enabled edge with pend=0, or with pend cleared by a slot load in the same cycle: pend<=1, pol<=edge type.
  - Enabled edge with pend=1 and that channel not loaded this cycle: event dropped, existing pol kept, ovf bit set.
  - Changing enables never affects an already pending event.
- Overflow: ovf bit set and ovf_clr_i bit in the same cycle: set wins. Otherwise ovf_clr_i clears.
- Arbitration, round-robin:
  - Search starts at pointer ptr and wraps modulo CHANNELS.
  - The first channel with pend=1 wins.
  - On a load, ptr<=winner+1, wrapping CHANNELS-1 -> 0.
  - ptr is unchanged when nothing loads.
- Output slot (registered):
  - Loads when (!evt_valid_o || evt_ready_i) and any pend=1.
  - Load writes evt_channel_o=winner, evt_rising_o=pol, evt_valid_o=1, and clears the winner's pend.
  - If evt_ready_i=1 with nothing pending: evt_valid_o<=0.
  - While evt_valid_o && !evt_ready_i, all evt_* outputs hold stable.
  - Throughput: one event per cycle under continuous ready.
- Latency: data_i change (stable before edge 0) to evt_valid_o=1 is SYNC_LEVELS+DEBOUNCE_CYCLES+2 edges when the slot is free. With defaults this is 8.

Test Plan:
- Reset, defaults, all enables=1. Raise data_i[2] and hold -> level_o[2]=1 after edge 6. evt_valid_o=1 after edge 8 with evt_channel_o=2, evt_rising_o=1. Ready=1 -> evt_valid_o=0 next cycle.
- Pulse data_i[0] high for 3 cycles, then low -> level_o[0] stays 0, no event, ovf_o=0.
- Raise data_i[0..3] in the same cycle, ready held 1 -> four consecutive events on channels 0,1,2,3, one per cycle. A second burst after ptr=0 again yields 0,1,2,3.
- Ready held 0; rising then falling on channel 1, each debounced -> slot shows ch1 rising. Pend holds ch1 falling. A third edge sets ovf_o[1]=1. Ready=1 then yields rising, then falling, with no third event.
- rise_en_i[3]=0, fall_en_i[3]=1; data_i[3] goes high then low -> only the falling event is output. level_o[3] tracks both transitions.
- Assert srst_i while evt_valid_o=1 and two pends are set -> next cycle all outputs are 0 and no events are output afterwards. ovf_o set in the same cycle as ovf_clr_i stays 1.
